// File: rtl/front_panel_ctrl.sv
// PDP-8 front panel: debounced buttons, run/halt tracking,
// display source selector and multiplexed octal display.
`timescale 1ns/1ps
module front_panel_ctrl #(
    parameter int NUM_BTN     = 5,
    parameter int DISP_BTN    = 4,
    parameter int DEB_CYCLES  = 1000000,
    parameter int NUM_SRC     = 4,
    parameter int DATA_W      = 12,
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_CYCLES = 262144
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic [NUM_BTN-1:0]         btn,
    input  logic                       run_sw,
    input  logic                       halt,
    input  logic [DATA_W-1:0]          dispout,
    input  logic                       linkout,
    output logic [NUM_BTN-1:0]         btn_pulse,
    output logic                       run,
    output logic                       run_led,
    output logic [$clog2(NUM_SRC)-1:0] dispsel,
    output logic [NUM_SRC-1:0]         sel_led,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [6:0]                 seg,
    output logic                       dp
);

    // run switch rides along as the top input of the debounce bank
    localparam int NIN  = NUM_BTN + 1;
    localparam int RSW  = NUM_BTN;
    localparam int CW   = $clog2(DEB_CYCLES);
    localparam int SELW = $clog2(NUM_SRC);
    localparam int NDIG = (DATA_W + 2) / 3;
    localparam int PADW = 3 * NDIG;
    localparam int DIGW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCW  = $clog2(SCAN_CYCLES);

    localparam logic [NUM_BTN-1:0] PMASK = ~(NUM_BTN'(1) << DISP_BTN);

    logic [NIN-1:0]  raw;
    logic [NIN-1:0]  meta;
    logic [NIN-1:0]  sync;
    logic [NIN-1:0]  stable;
    logic [NIN-1:0]  stable_d;
    logic [NIN-1:0]  rise;
    logic            run_fall;
    logic [CW-1:0]   cnt [NIN];

    logic [SCW-1:0]        scan_cnt;
    logic [DIGW-1:0]       digit;
    logic [PADW-1:0]       padded;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    assign raw = {run_sw, btn};

    // two-flop synchronizers on every raw input
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // counter debouncer: flip level after DEB_CYCLES mismatching samples
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stable <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise     = stable & ~stable_d;
    assign run_fall = ~stable[RSW] & stable_d[RSW];

    // delayed debounced levels for edge detection
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) stable_d <= '0;
        else         stable_d <= stable;
    end

    // press pulses; the display button is consumed locally
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) btn_pulse <= '0;
        else         btn_pulse <= rise[NUM_BTN-1:0] & PMASK;
    end

    // display source selector, wraps at NUM_SRC
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dispsel <= '0;
        end else if (rise[DISP_BTN]) begin
            if (dispsel == SELW'(NUM_SRC - 1)) dispsel <= '0;
            else                               dispsel <= dispsel + SELW'(1);
        end
    end

    assign sel_led = NUM_SRC'(1) << dispsel;

    // run flag: halt and switch release beat a fresh switch edge
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)                run <= 1'b0;
        else if (halt || run_fall)  run <= 1'b0;
        else if (rise[RSW])         run <= 1'b1;
    end

    assign run_led = run;

    // scan timer and digit index
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            if (digit == DIGW'(NUM_DIGITS - 1)) digit <= '0;
            else                                digit <= digit + DIGW'(1);
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    function automatic logic [6:0] oct2seg(input logic [2:0] v);
        logic [6:0] s;
        unique case (v)
            3'd0: s = 7'b1000000;
            3'd1: s = 7'b1111001;
            3'd2: s = 7'b0100100;
            3'd3: s = 7'b0110000;
            3'd4: s = 7'b0011001;
            3'd5: s = 7'b0010010;
            3'd6: s = 7'b0000010;
            3'd7: s = 7'b1111000;
        endcase
        return s;
    endfunction

    assign padded = PADW'(dispout);

    // digit decode: octal value, blank above the data, link on top dp
    always_comb begin
        an_n  = ~(NUM_DIGITS'(1) << digit);
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (digit == DIGW'(k)) begin
                seg_n = oct2seg(padded[3*k +: 3]);
                if (k == NDIG - 1) dp_n = ~linkout;
            end
        end
    end

    // registered display drive
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Bench for front_panel_ctrl: spec-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_front_panel_ctrl;

    localparam int NB  = 5;
    localparam int DB  = 4;
    localparam int DEB = 4;
    localparam int NS  = 4;
    localparam int ND  = 8;
    localparam int SC  = 2;

    localparam logic [6:0] SEGTAB [8] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

    logic          clock   = 1'b0;
    logic          resetN  = 1'b0;
    logic [NB-1:0] btn     = '0;
    logic          run_sw  = 1'b0;
    logic          halt    = 1'b0;
    logic          linkout = 1'b0;
    logic [11:0]   dispout   = '0;
    logic [12:0]   dispout13 = '0;

    logic [NB-1:0] btn_pulse, btn_pulse13;
    logic          run, run13, run_led, run_led13;
    logic [1:0]    dispsel, dispsel13;
    logic [NS-1:0] sel_led, sel_led13;
    logic [ND-1:0] an, an13;
    logic [6:0]    seg, seg13;
    logic          dp, dp13;

    int checks = 0;
    int errors = 0;
    int p4cnt  = 0;

    front_panel_ctrl #(
        .NUM_BTN(NB), .DISP_BTN(DB), .DEB_CYCLES(DEB), .NUM_SRC(NS),
        .DATA_W(12), .NUM_DIGITS(ND), .SCAN_CYCLES(SC)
    ) u_dut (
        .clock(clock), .resetN(resetN), .btn(btn), .run_sw(run_sw),
        .halt(halt), .dispout(dispout), .linkout(linkout),
        .btn_pulse(btn_pulse), .run(run), .run_led(run_led),
        .dispsel(dispsel), .sel_led(sel_led), .an(an), .seg(seg), .dp(dp)
    );

    front_panel_ctrl #(
        .NUM_BTN(NB), .DISP_BTN(DB), .DEB_CYCLES(DEB), .NUM_SRC(NS),
        .DATA_W(13), .NUM_DIGITS(ND), .SCAN_CYCLES(SC)
    ) u_dut13 (
        .clock(clock), .resetN(resetN), .btn(btn), .run_sw(run_sw),
        .halt(halt), .dispout(dispout13), .linkout(linkout),
        .btn_pulse(btn_pulse13), .run(run13), .run_led(run_led13),
        .dispsel(dispsel13), .sel_led(sel_led13), .an(an13),
        .seg(seg13), .dp(dp13)
    );

    always #5 clock = ~clock;

    always @(negedge clock) p4cnt <= p4cnt + int'(btn_pulse[DB]);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NB:0]   h [0:DEB+1];
    logic [NB:0]   m_stable = '0;
    logic [NB:0]   m_rose   = '0;
    logic [NB:0]   m_fell   = '0;
    logic [NB-1:0] m_pulse  = '0;
    logic          m_run    = 1'b0;
    int            m_sel    = 0;
    int            m_edge   = 0;
    logic [7:0]    e_an, e_an13;
    logic [6:0]    e_seg, e_seg13;
    logic          e_dp, e_dp13;

    // expected display after edge e for a value shown over ndig digits
    task automatic disp(input int e, input int ndig, input logic [31:0] val,
                        input logic lk, output logic [7:0] ean,
                        output logic [6:0] eseg, output logic edp);
        int k;
        ean  = 8'hFF;
        eseg = 7'h7F;
        edp  = 1'b1;
        if (e > 0) begin
            k   = ((e - 1) / SC) % ND;
            ean = ~(8'd1 << k);
            if (k < ndig) begin
                eseg = SEGTAB[(val >> (3 * k)) & 32'd7];
                if (k == ndig - 1) edp = ~lk;
            end
        end
    endtask

    task automatic model_step();
        logic [NB:0] prev;
        logic        flip;
        if (!resetN) begin
            for (int j = 0; j <= DEB + 1; j++) h[j] = '0;
            m_stable = '0;
            m_rose   = '0;
            m_fell   = '0;
            m_pulse  = '0;
            m_run    = 1'b0;
            m_sel    = 0;
            m_edge   = 0;
        end else begin
            m_edge++;
            m_pulse     = m_rose[NB-1:0];
            m_pulse[DB] = 1'b0;
            if (m_rose[DB]) m_sel = (m_sel + 1) % NS;
            if (halt || m_fell[NB]) m_run = 1'b0;
            else if (m_rose[NB])    m_run = 1'b1;
            for (int j = DEB + 1; j > 0; j--) h[j] = h[j-1];
            h[0] = {run_sw, btn};
            prev = m_stable;
            // level flips once the last DEB synchronized samples all differ
            for (int i = 0; i <= NB; i++) begin
                flip = 1'b1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (h[j][i] == prev[i]) flip = 1'b0;
                if (flip) m_stable[i] = ~prev[i];
            end
            m_rose = m_stable & ~prev;
            m_fell = prev & ~m_stable;
        end
        disp(m_edge, 4, 32'(dispout), linkout, e_an, e_seg, e_dp);
        disp(m_edge, 5, 32'(dispout13), linkout, e_an13, e_seg13, e_dp13);
    endtask

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            chk("cyc_pulse", 32'(btn_pulse), 32'(m_pulse));
            chk("cyc_run", 32'(run), 32'(m_run));
            chk("cyc_run_led", 32'(run_led), 32'(m_run));
            chk("cyc_dispsel", 32'(dispsel), m_sel);
            chk("cyc_sel_led", 32'(sel_led), 32'(1) << m_sel);
            chk("cyc_an", 32'(an), 32'(e_an));
            chk("cyc_seg", 32'(seg), 32'(e_seg));
            chk("cyc_dp", 32'(dp), 32'(e_dp));
            chk("cyc13_pulse", 32'(btn_pulse13), 32'(m_pulse));
            chk("cyc13_run", 32'(run13), 32'(m_run));
            chk("cyc13_run_led", 32'(run_led13), 32'(m_run));
            chk("cyc13_dispsel", 32'(dispsel13), m_sel);
            chk("cyc13_sel_led", 32'(sel_led13), 32'(1) << m_sel);
            chk("cyc13_an", 32'(an13), 32'(e_an13));
            chk("cyc13_seg", 32'(seg13), 32'(e_seg13));
            chk("cyc13_dp", 32'(dp13), 32'(e_dp13));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pulse"}, 32'(btn_pulse), 32'd0);
        chk({tag, "_run"}, 32'(run), 32'd0);
        chk({tag, "_run_led"}, 32'(run_led), 32'd0);
        chk({tag, "_dispsel"}, 32'(dispsel), 32'd0);
        chk({tag, "_sel_led"}, 32'(sel_led), 32'd1);
        chk({tag, "_an"}, 32'(an), 32'hFF);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    int sel_seq [5] = '{1, 2, 3, 0, 1};
    int led_seq [5] = '{2, 4, 8, 1, 2};
    logic [6:0] dig_seg [4] = '{7'b0010010, 7'b1111001,
                                7'b1000000, 7'b1111000};

    initial begin
        int lat, np, lat2, latr;
        logic [6:0] seg_cap [ND];
        logic       dp_cap  [ND];
        logic [6:0] seg13_cap4;
        logic       dp13_cap4;

        dispout   = 12'o7015;
        dispout13 = 13'h1000;
        linkout   = 1'b1;
        tick(2);
        chk_reset_vals("reset");
        resetN = 1'b1;
        tick(4);

        // bounce: three toggles two clocks apart, then hold
        btn[0] = 1'b1; tick(2);
        btn[0] = 1'b0; tick(2);
        btn[0] = 1'b1;
        lat = -1;
        np  = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (btn_pulse[0]) begin
                np++;
                if (lat < 0) lat = c;
            end
        end
        chk("bounce_latency", lat, 7);
        chk("bounce_count", np, 1);
        @(negedge clock);
        btn[0] = 1'b0;
        np = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clock); #1;
            if (btn_pulse[0]) np++;
        end
        chk("release_no_pulse", np, 0);

        // selector wrap over five presses
        for (int p = 0; p < 5; p++) begin
            @(negedge clock);
            btn[DB] = 1'b1; tick(10);
            btn[DB] = 1'b0; tick(10);
            chk("sel_dispsel", 32'(dispsel), sel_seq[p]);
            chk("sel_led", 32'(sel_led), led_seq[p]);
        end
        chk("disp_btn_masked", p4cnt, 0);

        // plain run, halt, switch behaviour
        run_sw = 1'b1; tick(10);
        chk("run_set", 32'(run), 32'd1);
        chk("run_led_set", 32'(run_led), 32'd1);
        halt = 1'b1; tick(1);
        halt = 1'b0;
        chk("halt_clears", 32'(run), 32'd0);
        tick(10);
        chk("held_no_reset", 32'(run), 32'd0);
        run_sw = 1'b0; tick(10);

        // halt lands with the debounced rising edge
        run_sw = 1'b1; tick(6);
        halt = 1'b1; tick(1);
        halt = 1'b0;
        chk("race_halt_wins", 32'(run), 32'd0);
        tick(10);
        chk("race_stays_0", 32'(run), 32'd0);
        run_sw = 1'b0; tick(10);
        run_sw = 1'b1; tick(10);
        chk("rearm_run", 32'(run), 32'd1);
        run_sw = 1'b0; tick(10);
        chk("sw_fall_clears", 32'(run), 32'd0);
        run_sw = 1'b1; tick(10);

        // scan and decode over a full rotation
        for (int k = 0; k < ND; k++) begin
            seg_cap[k] = 7'h00;
            dp_cap[k]  = 1'b0;
        end
        seg13_cap4 = 7'h00;
        dp13_cap4  = 1'b1;
        for (int c = 0; c < SC * ND + SC; c++) begin
            @(posedge clock); #1;
            for (int k = 0; k < ND; k++) begin
                if (an == ~(8'd1 << k)) begin
                    seg_cap[k] = seg;
                    dp_cap[k]  = dp;
                end
            end
            if (an13 == 8'hEF) begin
                seg13_cap4 = seg13;
                dp13_cap4  = dp13;
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk("scan_digit_seg", 32'(seg_cap[k]), 32'(dig_seg[k]));
            chk("scan_digit_dp", 32'(dp_cap[k]), (k == 3) ? 32'd0 : 32'd1);
        end
        for (int k = 4; k < ND; k++) begin
            chk("scan_blank_seg", 32'(seg_cap[k]), 32'h7F);
            chk("scan_blank_dp", 32'(dp_cap[k]), 32'd1);
        end
        chk("odd_width_seg", 32'(seg13_cap4), 32'h79);
        chk("odd_width_dp", 32'(dp13_cap4), 32'd0);

        // async reset mid-debounce and mid-run
        @(negedge clock);
        btn[1] = 1'b1;
        tick(3);
        #2 resetN = 1'b0;
        #1 chk_reset_vals("async_rst");
        btn[1] = 1'b0;
        btn[2] = 1'b1;
        tick(3);
        resetN = 1'b1;
        lat2 = -1;
        latr = -1;
        np   = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clock); #1;
            if (btn_pulse[2] && lat2 < 0) lat2 = c;
            if (run && latr < 0) latr = c;
            if (btn_pulse[1]) np++;
        end
        chk("held_btn_latency", lat2, 7);
        chk("held_run_latency", latr, 7);
        chk("no_stray_pulse", np, 0);

        @(negedge clock);
        btn[2] = 1'b0;
        run_sw = 1'b0;
        tick(12);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
